// File: rtl/dvi_timing_gen.sv
// Raster timing generator: free-running h/v counters produce pixel coordinates,
// line/frame pulses, and hsync/vsync/DE delayed to match the pixel source latency.
module dvi_timing_gen #(
   parameter int SCREEN_H_RES = 640,
   parameter int SCREEN_V_RES = 480,
   parameter int HSYNC_START  = 656,
   parameter int HSYNC_END    = 752,
   parameter int H_TOTAL      = 800,
   parameter int VSYNC_START  = 490,
   parameter int VSYNC_END    = 492,
   parameter int V_TOTAL      = 525,
   parameter bit HS_POL       = 1'b0,
   parameter bit VS_POL       = 1'b0,
   parameter int DEL_CYCLES   = 1,
   parameter int X_POS_W      = 10,
   parameter int Y_POS_W      = 9,
   parameter int HS_W         = 10,
   parameter int VS_W         = 10
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               en_i,
   output logic [X_POS_W-1:0] x_pos_o,
   output logic [Y_POS_W-1:0] y_pos_o,
   output logic               frame_start_o,
   output logic               line_start_o,
   output logic               hsync_o,
   output logic               vsync_o,
   output logic               de_o
);

   if (DEL_CYCLES < 0 || DEL_CYCLES > 8 ||
       SCREEN_H_RES > HSYNC_START || HSYNC_START >= HSYNC_END || HSYNC_END > H_TOTAL ||
       SCREEN_V_RES > VSYNC_START || VSYNC_START >= VSYNC_END || VSYNC_END > V_TOTAL ||
       H_TOTAL > (1 << HS_W) || V_TOTAL > (1 << VS_W)) begin : g_param_err
      $error("dvi_timing_gen: illegal timing parameters");
   end

   localparam logic [HS_W-1:0] H_RES_C    = HS_W'(SCREEN_H_RES);
   localparam logic [HS_W-1:0] H_SYNC_S_C = HS_W'(HSYNC_START);
   localparam logic [HS_W-1:0] H_SYNC_E_C = HS_W'(HSYNC_END);
   localparam logic [HS_W-1:0] H_LAST_C   = HS_W'(H_TOTAL - 1);
   localparam logic [VS_W-1:0] V_RES_C    = VS_W'(SCREEN_V_RES);
   localparam logic [VS_W-1:0] V_SYNC_S_C = VS_W'(VSYNC_START);
   localparam logic [VS_W-1:0] V_SYNC_E_C = VS_W'(VSYNC_END);
   localparam logic [VS_W-1:0] V_LAST_C   = VS_W'(V_TOTAL - 1);

   logic [HS_W-1:0] h_cnt;
   logic [VS_W-1:0] v_cnt;
   logic            de_raw;
   logic            hs_raw;
   logic            vs_raw;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (en_i) begin
         if (h_cnt == H_LAST_C) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST_C) ? '0 : v_cnt + VS_W'(1);
         end else begin
            h_cnt <= h_cnt + HS_W'(1);
         end
      end
   end

   // vsync depends on v_cnt alone, so it changes at the start of a line
   always_comb begin
      de_raw = (h_cnt < H_RES_C) && (v_cnt < V_RES_C);
      hs_raw = ((h_cnt >= H_SYNC_S_C) && (h_cnt < H_SYNC_E_C)) ? HS_POL : ~HS_POL;
      vs_raw = ((v_cnt >= V_SYNC_S_C) && (v_cnt < V_SYNC_E_C)) ? VS_POL : ~VS_POL;
   end

   always_comb begin
      x_pos_o       = (h_cnt < H_RES_C) ? X_POS_W'(h_cnt) : '0;
      y_pos_o       = (v_cnt < V_RES_C) ? Y_POS_W'(v_cnt) : '0;
      line_start_o  = rst_n_i && en_i && (h_cnt == '0);
      frame_start_o = rst_n_i && en_i && (h_cnt == '0) && (v_cnt == '0);
   end

   if (DEL_CYCLES == 0) begin : g_no_delay
      // Counters sit at 0,0 in reset, so only DE needs explicit gating
      always_comb begin
         de_o    = rst_n_i && de_raw;
         hsync_o = rst_n_i ? hs_raw : ~HS_POL;
         vsync_o = rst_n_i ? vs_raw : ~VS_POL;
      end
   end else begin : g_delay
      logic [DEL_CYCLES-1:0] de_sr;
      logic [DEL_CYCLES-1:0] hs_sr;
      logic [DEL_CYCLES-1:0] vs_sr;

      always_ff @(posedge clk_i or negedge rst_n_i) begin
         if (!rst_n_i) begin
            de_sr <= '0;
            hs_sr <= {DEL_CYCLES{~HS_POL}};
            vs_sr <= {DEL_CYCLES{~VS_POL}};
         end else if (en_i) begin
            de_sr[0] <= de_raw;
            hs_sr[0] <= hs_raw;
            vs_sr[0] <= vs_raw;
            for (int i = 1; i < DEL_CYCLES; i++) begin
               de_sr[i] <= de_sr[i-1];
               hs_sr[i] <= hs_sr[i-1];
               vs_sr[i] <= vs_sr[i-1];
            end
         end
      end

      always_comb begin
         de_o    = de_sr[DEL_CYCLES-1];
         hsync_o = hs_sr[DEL_CYCLES-1];
         vsync_o = vs_sr[DEL_CYCLES-1];
      end
   end

endmodule
